// File: rtl/axi4lite_pkg.sv
// ---------------------------------------------------------------------------
// axi4lite_pkg
//   Shared definitions for the AXI4-Lite register slice:
//     - PROT/RESP field widths and the four AXI response codes
//     - default-width packed payload structs for each channel
//     - state encoding for the per-channel skid buffer
//   The top level builds its own payload structs from its AWIDTH/DWIDTH
//   parameters; the structs here describe the default 12/32 configuration.
// ---------------------------------------------------------------------------
package axi4lite_pkg;

    localparam int PROT_W = 3;
    localparam int RESP_W = 2;

    localparam int AWIDTH = 12;
    localparam int DWIDTH = 32;

    localparam logic [RESP_W-1:0] OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] EXOKAY = 2'b01;
    localparam logic [RESP_W-1:0] SLVERR = 2'b10;
    localparam logic [RESP_W-1:0] DECERR = 2'b11;

    // AR and AW carry the same payload
    typedef struct packed {
        logic [AWIDTH-1:0] addr;
        logic [PROT_W-1:0] prot;
    } ax_payload_t;

    typedef struct packed {
        logic [DWIDTH-1:0]   data;
        logic [DWIDTH/8-1:0] strb;
    } w_payload_t;

    typedef struct packed {
        logic [DWIDTH-1:0] data;
        logic [RESP_W-1:0] resp;
    } r_payload_t;

    typedef struct packed {
        logic [RESP_W-1:0] resp;
    } b_payload_t;

    // EMPTY: nothing held; BUSY: OUT holds a beat; FULL: OUT and SKID hold beats
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/axi_skid_buffer.sv
// ---------------------------------------------------------------------------
// axi_skid_buffer
//   Two-entry fully registered valid/ready pipeline stage. Valid, ready and
//   payload outputs all come straight from flops, so no combinational path
//   crosses the stage in either direction.
//
//   Ports
//     i_aClk     clock, rising edge
//     i_aResetn  asynchronous active-low reset
//     i_valid    upstream valid          o_ready  upstream ready (registered)
//     i_data     upstream payload
//     o_valid    downstream valid (reg)  i_ready  downstream ready
//     o_data     downstream payload, always the OUT register
// ---------------------------------------------------------------------------
module axi_skid_buffer
    import axi4lite_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_aClk,
    input  logic             i_aResetn,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    skid_state_t      state_reg, state_next;
    logic [WIDTH-1:0] out_reg, out_next;
    logic [WIDTH-1:0] skid_reg, skid_next;
    logic             ready_reg, ready_next;
    logic             valid_reg, valid_next;

    logic in_fire;
    logic out_fire;

    assign in_fire  = i_valid & ready_reg;
    assign out_fire = valid_reg & i_ready;

    always_comb begin
        state_next = state_reg;
        out_next   = out_reg;
        skid_next  = skid_reg;

        unique case (state_reg)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_next = ST_BUSY;
                    out_next   = i_data;
                end
            end
            ST_BUSY: begin
                if (in_fire && out_fire) begin
                    out_next = i_data;
                end else if (out_fire) begin
                    state_next = ST_EMPTY;
                end else if (in_fire) begin
                    // downstream stalled: park the new beat behind OUT
                    state_next = ST_FULL;
                    skid_next  = i_data;
                end
            end
            ST_FULL: begin
                // ready is low here, so only a drain can happen
                if (out_fire) begin
                    state_next = ST_BUSY;
                    out_next   = skid_reg;
                end
            end
            default: begin
                state_next = ST_EMPTY;
            end
        endcase

        // Handshake flags are registered copies of the next-state decode
        ready_next = (state_next != ST_FULL);
        valid_next = (state_next != ST_EMPTY);
    end

    always_ff @(posedge i_aClk or negedge i_aResetn) begin
        if (!i_aResetn) begin
            state_reg <= ST_EMPTY;
            out_reg   <= '0;
            skid_reg  <= '0;
            ready_reg <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            out_reg   <= out_next;
            skid_reg  <= skid_next;
            ready_reg <= ready_next;
            valid_reg <= valid_next;
        end
    end

    assign o_ready = ready_reg;
    assign o_valid = valid_reg;
    assign o_data  = out_reg;

endmodule

// File: rtl/axi4lite_reg_slice.sv
// ---------------------------------------------------------------------------
// axi4lite_reg_slice
//   Fully registered AXI4-Lite pipeline stage. Each of the five channels runs
//   through its own independent skid buffer: one cycle of forward latency,
//   full throughput, no combinational path between the two sides.
//
//   Ports (s = master side, m = slave side)
//     i_aClk, i_aResetn             clock and async active-low reset
//     AR: i_sAr* -> o_mAr*          read address   (addr AWIDTH, prot 3)
//     AW: i_sAw* -> o_mAw*          write address  (addr AWIDTH, prot 3)
//     W : i_sW*  -> o_mW*           write data     (data DWIDTH, strb DWIDTH/8)
//     R : i_mR*  -> o_sR*           read data      (data DWIDTH, resp 2)
//     B : i_mB*  -> o_sB*           write response (resp 2)
// ---------------------------------------------------------------------------
module axi4lite_reg_slice
    import axi4lite_pkg::*;
#(
    parameter int AWIDTH = 12,
    parameter int DWIDTH = 32
) (
    input  logic                i_aClk,
    input  logic                i_aResetn,

    input  logic                i_sArValid,
    output logic                o_sArReady,
    input  logic [AWIDTH-1:0]   i_sArAddr,
    input  logic [PROT_W-1:0]   i_sArProt,
    output logic                o_mArValid,
    input  logic                i_mArReady,
    output logic [AWIDTH-1:0]   o_mArAddr,
    output logic [PROT_W-1:0]   o_mArProt,

    output logic                o_sRValid,
    input  logic                i_sRReady,
    output logic [DWIDTH-1:0]   o_sRData,
    output logic [RESP_W-1:0]   o_sRResp,
    input  logic                i_mRValid,
    output logic                o_mRReady,
    input  logic [DWIDTH-1:0]   i_mRData,
    input  logic [RESP_W-1:0]   i_mRResp,

    input  logic                i_sAwValid,
    output logic                o_sAwReady,
    input  logic [AWIDTH-1:0]   i_sAwAddr,
    input  logic [PROT_W-1:0]   i_sAwProt,
    output logic                o_mAwValid,
    input  logic                i_mAwReady,
    output logic [AWIDTH-1:0]   o_mAwAddr,
    output logic [PROT_W-1:0]   o_mAwProt,

    input  logic                i_sWValid,
    output logic                o_sWReady,
    input  logic [DWIDTH-1:0]   i_sWData,
    input  logic [DWIDTH/8-1:0] i_sWStrb,
    output logic                o_mWValid,
    input  logic                i_mWReady,
    output logic [DWIDTH-1:0]   o_mWData,
    output logic [DWIDTH/8-1:0] o_mWStrb,

    output logic                o_sBValid,
    input  logic                i_sBReady,
    output logic [RESP_W-1:0]   o_sBResp,
    input  logic                i_mBValid,
    output logic                o_mBReady,
    input  logic [RESP_W-1:0]   i_mBResp
);

    if (DWIDTH != 32 && DWIDTH != 64) begin : g_bad_dwidth
        $error("axi4lite_reg_slice: DWIDTH must be 32 or 64");
    end

    typedef struct packed {
        logic [AWIDTH-1:0] addr;
        logic [PROT_W-1:0] prot;
    } ax_t;

    typedef struct packed {
        logic [DWIDTH-1:0]   data;
        logic [DWIDTH/8-1:0] strb;
    } w_t;

    typedef struct packed {
        logic [DWIDTH-1:0] data;
        logic [RESP_W-1:0] resp;
    } r_t;

    typedef struct packed {
        logic [RESP_W-1:0] resp;
    } b_t;

    ax_t ar_in, ar_out;
    ax_t aw_in, aw_out;
    w_t  w_in,  w_out;
    r_t  r_in,  r_out;
    b_t  b_in,  b_out;

    assign ar_in = '{addr: i_sArAddr, prot: i_sArProt};
    assign aw_in = '{addr: i_sAwAddr, prot: i_sAwProt};
    assign w_in  = '{data: i_sWData,  strb: i_sWStrb};
    assign r_in  = '{data: i_mRData,  resp: i_mRResp};
    assign b_in  = '{resp: i_mBResp};

    // Read address: master -> slave
    axi_skid_buffer #(.WIDTH($bits(ax_t))) u_ar (
        .i_aClk    (i_aClk),
        .i_aResetn (i_aResetn),
        .i_valid   (i_sArValid),
        .o_ready   (o_sArReady),
        .i_data    (ar_in),
        .o_valid   (o_mArValid),
        .i_ready   (i_mArReady),
        .o_data    (ar_out)
    );

    // Write address: master -> slave
    axi_skid_buffer #(.WIDTH($bits(ax_t))) u_aw (
        .i_aClk    (i_aClk),
        .i_aResetn (i_aResetn),
        .i_valid   (i_sAwValid),
        .o_ready   (o_sAwReady),
        .i_data    (aw_in),
        .o_valid   (o_mAwValid),
        .i_ready   (i_mAwReady),
        .o_data    (aw_out)
    );

    // Write data: master -> slave
    axi_skid_buffer #(.WIDTH($bits(w_t))) u_w (
        .i_aClk    (i_aClk),
        .i_aResetn (i_aResetn),
        .i_valid   (i_sWValid),
        .o_ready   (o_sWReady),
        .i_data    (w_in),
        .o_valid   (o_mWValid),
        .i_ready   (i_mWReady),
        .o_data    (w_out)
    );

    // Read data: slave -> master
    axi_skid_buffer #(.WIDTH($bits(r_t))) u_r (
        .i_aClk    (i_aClk),
        .i_aResetn (i_aResetn),
        .i_valid   (i_mRValid),
        .o_ready   (o_mRReady),
        .i_data    (r_in),
        .o_valid   (o_sRValid),
        .i_ready   (i_sRReady),
        .o_data    (r_out)
    );

    // Write response: slave -> master
    axi_skid_buffer #(.WIDTH($bits(b_t))) u_b (
        .i_aClk    (i_aClk),
        .i_aResetn (i_aResetn),
        .i_valid   (i_mBValid),
        .o_ready   (o_mBReady),
        .i_data    (b_in),
        .o_valid   (o_sBValid),
        .i_ready   (i_sBReady),
        .o_data    (b_out)
    );

    assign o_mArAddr = ar_out.addr;
    assign o_mArProt = ar_out.prot;
    assign o_mAwAddr = aw_out.addr;
    assign o_mAwProt = aw_out.prot;
    assign o_mWData  = w_out.data;
    assign o_mWStrb  = w_out.strb;
    assign o_sRData  = r_out.data;
    assign o_sRResp  = r_out.resp;
    assign o_sBResp  = b_out.resp;

endmodule

// File: tb/tb_axi4lite_reg_slice.sv
module tb_axi4lite_reg_slice;
    import axi4lite_pkg::*;

    logic        i_aClk = 1'b0;
    logic        i_aResetn;

    logic        i_sArValid, o_sArReady, o_mArValid, i_mArReady;
    logic [11:0] i_sArAddr, o_mArAddr;
    logic [2:0]  i_sArProt, o_mArProt;
    logic        o_sRValid, i_sRReady, i_mRValid, o_mRReady;
    logic [31:0] o_sRData, i_mRData;
    logic [1:0]  o_sRResp, i_mRResp;
    logic        i_sAwValid, o_sAwReady, o_mAwValid, i_mAwReady;
    logic [11:0] i_sAwAddr, o_mAwAddr;
    logic [2:0]  i_sAwProt, o_mAwProt;
    logic        i_sWValid, o_sWReady, o_mWValid, i_mWReady;
    logic [31:0] i_sWData, o_mWData;
    logic [3:0]  i_sWStrb, o_mWStrb;
    logic        o_sBValid, i_sBReady, i_mBValid, o_mBReady;
    logic [1:0]  o_sBResp, i_mBResp;

    int checks = 0;
    int errors = 0;

    always #5 i_aClk = ~i_aClk;

    axi4lite_reg_slice #(.AWIDTH(12), .DWIDTH(32)) dut (
        .i_aClk(i_aClk), .i_aResetn(i_aResetn),
        .i_sArValid(i_sArValid), .o_sArReady(o_sArReady), .i_sArAddr(i_sArAddr), .i_sArProt(i_sArProt),
        .o_mArValid(o_mArValid), .i_mArReady(i_mArReady), .o_mArAddr(o_mArAddr), .o_mArProt(o_mArProt),
        .o_sRValid(o_sRValid), .i_sRReady(i_sRReady), .o_sRData(o_sRData), .o_sRResp(o_sRResp),
        .i_mRValid(i_mRValid), .o_mRReady(o_mRReady), .i_mRData(i_mRData), .i_mRResp(i_mRResp),
        .i_sAwValid(i_sAwValid), .o_sAwReady(o_sAwReady), .i_sAwAddr(i_sAwAddr), .i_sAwProt(i_sAwProt),
        .o_mAwValid(o_mAwValid), .i_mAwReady(i_mAwReady), .o_mAwAddr(o_mAwAddr), .o_mAwProt(o_mAwProt),
        .i_sWValid(i_sWValid), .o_sWReady(o_sWReady), .i_sWData(i_sWData), .i_sWStrb(i_sWStrb),
        .o_mWValid(o_mWValid), .i_mWReady(i_mWReady), .o_mWData(o_mWData), .o_mWStrb(o_mWStrb),
        .o_sBValid(o_sBValid), .i_sBReady(i_sBReady), .o_sBResp(o_sBResp),
        .i_mBValid(i_mBValid), .o_mBReady(o_mBReady), .i_mBResp(i_mBResp)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_aClk);
        #1;
    endtask

    // Channel index: 0 AR, 1 AW, 2 W, 3 R, 4 B. Payloads packed low-aligned.
    function automatic logic [63:0] width_mask(input int ch);
        case (ch)
            0, 1:    return (64'd1 << 15) - 64'd1;
            2:       return (64'd1 << 36) - 64'd1;
            3:       return (64'd1 << 34) - 64'd1;
            default: return 64'd3;
        endcase
    endfunction

    function automatic logic up_ready(input int ch);
        case (ch)
            0:       return o_sArReady;
            1:       return o_sAwReady;
            2:       return o_sWReady;
            3:       return o_mRReady;
            default: return o_mBReady;
        endcase
    endfunction

    function automatic logic dn_valid(input int ch);
        case (ch)
            0:       return o_mArValid;
            1:       return o_mAwValid;
            2:       return o_mWValid;
            3:       return o_sRValid;
            default: return o_sBValid;
        endcase
    endfunction

    function automatic logic [63:0] dn_data(input int ch);
        case (ch)
            0:       return 64'({o_mArAddr, o_mArProt});
            1:       return 64'({o_mAwAddr, o_mAwProt});
            2:       return 64'({o_mWData, o_mWStrb});
            3:       return 64'({o_sRData, o_sRResp});
            default: return 64'(o_sBResp);
        endcase
    endfunction

    task automatic drive_src(input int ch, input logic v, input logic [63:0] d);
        case (ch)
            0: begin i_sArValid = v; {i_sArAddr, i_sArProt} = d[14:0]; end
            1: begin i_sAwValid = v; {i_sAwAddr, i_sAwProt} = d[14:0]; end
            2: begin i_sWValid  = v; {i_sWData, i_sWStrb}   = d[35:0]; end
            3: begin i_mRValid  = v; {i_mRData, i_mRResp}   = d[33:0]; end
            default: begin i_mBValid = v; i_mBResp = d[1:0]; end
        endcase
    endtask

    task automatic drive_dst(input int ch, input logic r);
        case (ch)
            0:       i_mArReady = r;
            1:       i_mAwReady = r;
            2:       i_mWReady  = r;
            3:       i_sRReady  = r;
            default: i_sBReady  = r;
        endcase
    endtask

    task automatic idle_all();
        for (int ch = 0; ch < 5; ch++) begin
            drive_src(ch, 1'b0, 64'd0);
            drive_dst(ch, 1'b0);
        end
    endtask

    // Scoreboard state for the randomised phase
    logic [63:0] exp_mem [5][16];
    int          wr_ptr [5];
    int          rd_ptr [5];
    logic        src_v  [5];
    logic [63:0] src_d  [5];
    logic        dst_r  [5];
    logic        prev_v [5];
    logic        prev_r [5];
    logic [63:0] prev_d [5];

    task automatic run_cycles(input int n, input bit randomise);
        logic        fired [5];
        logic        v;
        logic [63:0] d;
        for (int c = 0; c < n; c++) begin
            @(negedge i_aClk);
            for (int ch = 0; ch < 5; ch++) begin
                v = dn_valid(ch);
                d = dn_data(ch);
                fired[ch] = 1'b0;
                if (prev_v[ch] && !prev_r[ch]) begin
                    check("rnd_hold_valid", 64'(v), 64'd1);
                    check("rnd_hold_data", d, prev_d[ch]);
                end
                if (v && dst_r[ch]) begin
                    check("rnd_no_extra_beat", 64'(rd_ptr[ch] != wr_ptr[ch]), 64'd1);
                    if (rd_ptr[ch] != wr_ptr[ch]) begin
                        check("rnd_order_data", d, exp_mem[ch][rd_ptr[ch] % 16]);
                        rd_ptr[ch]++;
                    end
                end
                if (src_v[ch] && up_ready(ch)) begin
                    exp_mem[ch][wr_ptr[ch] % 16] = src_d[ch];
                    wr_ptr[ch]++;
                    fired[ch] = 1'b1;
                end
                prev_v[ch] = v;
                prev_r[ch] = dst_r[ch];
                prev_d[ch] = d;
            end
            tick();
            for (int ch = 0; ch < 5; ch++) begin
                if (randomise) begin
                    if (!src_v[ch] || fired[ch]) begin
                        src_v[ch] = ($urandom_range(0, 3) != 0);
                        src_d[ch] = {$urandom, $urandom} & width_mask(ch);
                    end
                    dst_r[ch] = ($urandom_range(0, 2) != 0);
                end else begin
                    if (fired[ch]) src_v[ch] = 1'b0;
                    dst_r[ch] = 1'b1;
                end
                drive_src(ch, src_v[ch], src_d[ch]);
                drive_dst(ch, dst_r[ch]);
            end
        end
    endtask

    typedef struct {
        logic        valid;
        logic [11:0] addr;
        logic        m_ready;
        logic        exp_s_ready;
        logic        exp_m_valid;
        logic [11:0] exp_m_addr;
    } ar_vec_t;

    ar_vec_t vecs [8];
    int      hs_count;

    initial begin
        // AR stall/skid sequence: one record per cycle, outputs checked before the edge
        vecs[0] = '{1'b1, 12'h100, 1'b0, 1'b1, 1'b0, 12'h000};
        vecs[1] = '{1'b1, 12'h104, 1'b0, 1'b1, 1'b1, 12'h100};
        vecs[2] = '{1'b1, 12'h108, 1'b0, 1'b0, 1'b1, 12'h100};
        vecs[3] = '{1'b1, 12'h108, 1'b0, 1'b0, 1'b1, 12'h100};
        vecs[4] = '{1'b1, 12'h108, 1'b1, 1'b0, 1'b1, 12'h100};
        vecs[5] = '{1'b1, 12'h108, 1'b1, 1'b1, 1'b1, 12'h104};
        vecs[6] = '{1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 12'h108};
        vecs[7] = '{1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 12'h108};

        idle_all();
        i_aResetn = 1'b0;
        repeat (3) tick();

        // ---- reset state ----
        for (int ch = 0; ch < 5; ch++) begin
            check("rst_up_ready", 64'(up_ready(ch)), 64'd0);
            check("rst_dn_valid", 64'(dn_valid(ch)), 64'd0);
            check("rst_dn_data", dn_data(ch), 64'd0);
        end
        i_aResetn = 1'b1;
        check("rst_ready_before_edge", 64'(o_sArReady), 64'd0);
        tick();
        for (int ch = 0; ch < 5; ch++)
            check("rst_ready_after_edge", 64'(up_ready(ch)), 64'd1);

        // ---- AR stall/skid table ----
        for (int i = 0; i < 8; i++) begin
            i_sArValid = vecs[i].valid;
            i_sArAddr  = vecs[i].addr;
            i_sArProt  = 3'd0;
            i_mArReady = vecs[i].m_ready;
            check("ar_s_ready", 64'(o_sArReady), 64'(vecs[i].exp_s_ready));
            check("ar_m_valid", 64'(o_mArValid), 64'(vecs[i].exp_m_valid));
            check("ar_m_addr", 64'(o_mArAddr), 64'(vecs[i].exp_m_addr));
            if (o_mArValid && i_mArReady) $display("AR beat addr %03h", o_mArAddr);
            tick();
        end
        idle_all();

        // ---- streaming write, 16 beats, downstream always ready ----
        for (int i = 0; i < 18; i++) begin
            i_sAwValid = (i < 16);
            i_sWValid  = (i < 16);
            if (i < 16) begin
                i_sAwAddr = 12'h010 + 12'(i);
                i_sAwProt = 3'd2;
                i_sWData  = 32'hA5A50000 + 32'(i);
                i_sWStrb  = 4'hF;
            end
            i_mAwReady = 1'b1;
            i_mWReady  = 1'b1;
            check("aw_s_ready", 64'(o_sAwReady), 64'd1);
            check("w_s_ready", 64'(o_sWReady), 64'd1);
            check("aw_m_valid", 64'(o_mAwValid), 64'(i >= 1 && i <= 16));
            check("w_m_valid", 64'(o_mWValid), 64'(i >= 1 && i <= 16));
            if (i >= 1 && i <= 16) begin
                check("aw_m_addr", 64'(o_mAwAddr), 64'(12'h010 + 12'(i - 1)));
                check("aw_m_prot", 64'(o_mAwProt), 64'd2);
                check("w_m_data", 64'(o_mWData), 64'(32'hA5A50000 + 32'(i - 1)));
                check("w_m_strb", 64'(o_mWStrb), 64'hF);
                $display("AW/W beat addr %03h data %08h", o_mAwAddr, o_mWData);
            end
            tick();
        end
        idle_all();

        // ---- R response with master ready toggling ----
        hs_count = 0;
        for (int k = 0; k < 8; k++) begin
            i_mRValid = (k == 0);
            i_mRData  = 32'hDEADBEEF;
            i_mRResp  = SLVERR;
            i_sRReady = (k % 2 == 0);
            check("r_m_ready", 64'(o_mRReady), 64'd1);
            check("r_s_valid", 64'(o_sRValid), 64'(k == 1 || k == 2));
            if (o_sRValid) begin
                check("r_s_data", 64'(o_sRData), 64'hDEADBEEF);
                check("r_s_resp", 64'(o_sRResp), 64'(SLVERR));
                if (i_sRReady) begin
                    hs_count++;
                    $display("R beat data %08h resp %0d", o_sRData, o_sRResp);
                end
            end
            tick();
        end
        check("r_delivered_once", 64'(hs_count), 64'd1);
        idle_all();

        // ---- B stalled while AR and R stream at full rate ----
        for (int i = 0; i < 10; i++) begin
            i_sArValid = (i < 8);
            i_sArAddr  = 12'h200 + 12'(4 * i);
            i_sArProt  = 3'd0;
            i_mArReady = 1'b1;
            i_mRValid  = (i < 8);
            i_mRData   = 32'h1000 + 32'(i);
            i_mRResp   = OKAY;
            i_sRReady  = 1'b1;
            i_mBValid  = (i < 2);
            i_mBResp   = (i == 0) ? OKAY : DECERR;
            i_sBReady  = 1'b0;
            check("ind_ar_s_ready", 64'(o_sArReady), 64'd1);
            check("ind_r_m_ready", 64'(o_mRReady), 64'd1);
            check("ind_ar_valid", 64'(o_mArValid), 64'(i >= 1 && i <= 8));
            check("ind_r_valid", 64'(o_sRValid), 64'(i >= 1 && i <= 8));
            if (i >= 1 && i <= 8) begin
                check("ind_ar_addr", 64'(o_mArAddr), 64'(12'h200 + 12'(4 * (i - 1))));
                check("ind_r_data", 64'(o_sRData), 64'(32'h1000 + 32'(i - 1)));
            end
            if (i >= 2) begin
                check("ind_b_m_ready", 64'(o_mBReady), 64'd0);
                check("ind_b_valid", 64'(o_sBValid), 64'd1);
                check("ind_b_resp", 64'(o_sBResp), 64'(OKAY));
            end
            tick();
        end
        idle_all();
        for (int j = 0; j < 3; j++) begin
            i_sBReady = 1'b1;
            check("b_rel_valid", 64'(o_sBValid), 64'(j < 2));
            if (j < 2) begin
                check("b_rel_resp", 64'(o_sBResp), 64'((j == 0) ? OKAY : DECERR));
                $display("B beat resp %0d", o_sBResp);
            end
            if (j >= 1) check("b_rel_m_ready", 64'(o_mBReady), 64'd1);
            tick();
        end
        idle_all();

        // ---- asynchronous reset with AR SKID full ----
        i_sArValid = 1'b1; i_sArAddr = 12'h300; i_mArReady = 1'b0;
        tick();
        i_sArAddr = 12'h304;
        tick();
        i_sArValid = 1'b0;
        check("pre_rst_ar_full", 64'(o_sArReady), 64'd0);
        #2 i_aResetn = 1'b0;
        #1;
        check("async_rst_ar_ready", 64'(o_sArReady), 64'd0);
        check("async_rst_ar_valid", 64'(o_mArValid), 64'd0);
        check("async_rst_ar_addr", 64'(o_mArAddr), 64'd0);
        for (int ch = 1; ch < 5; ch++) begin
            check("async_rst_up_ready", 64'(up_ready(ch)), 64'd0);
            check("async_rst_dn_valid", 64'(dn_valid(ch)), 64'd0);
            check("async_rst_dn_data", dn_data(ch), 64'd0);
        end
        tick();
        i_aResetn = 1'b1;
        check("rst2_ready_before_edge", 64'(o_sArReady), 64'd0);
        tick();
        check("rst2_ar_ready", 64'(o_sArReady), 64'd1);
        check("rst2_ar_valid", 64'(o_mArValid), 64'd0);
        i_mArReady = 1'b1;
        tick();
        check("rst2_no_stale_beat", 64'(o_mArValid), 64'd0);
        idle_all();

        // ---- randomised valid/ready on all channels, then drain ----
        for (int ch = 0; ch < 5; ch++) begin
            wr_ptr[ch] = 0; rd_ptr[ch] = 0;
            src_v[ch] = 1'b0; src_d[ch] = 64'd0; dst_r[ch] = 1'b0;
            prev_v[ch] = 1'b0; prev_r[ch] = 1'b0; prev_d[ch] = 64'd0;
        end
        run_cycles(10000, 1'b1);
        run_cycles(6, 1'b0);
        for (int ch = 0; ch < 5; ch++) begin
            check("rnd_all_delivered", 64'(rd_ptr[ch]), 64'(wr_ptr[ch]));
            check("rnd_traffic_seen", 64'(wr_ptr[ch] > 1000), 64'd1);
            $display("channel %0d random beats %0d", ch, wr_ptr[ch]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
